// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the display scan controller.
//   NUM_DIGITS  - number of multiplexed digits
//   ANODE_OFF   - all-anodes-off pattern (active-low anodes)
//   state_t     - scan phase: ST_BLANK (dead time) / ST_DRIVE (digit lit)
//   lz_mask()   - leading-zero blank vector for a 16-bit display word
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  ANODE_OFF  = 4'b1111;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    // Bit i set when lz is on, i != 0, and nibbles 3..i are all zero.
    // Digit 0 is never suppressed so a zero value still shows "0".
    function automatic logic [3:0] lz_mask(input logic [15:0] value, input logic lz);
        logic [3:0] m;
        logic       all_zero;
        int unsigned i;
        m        = '0;
        all_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            i        = NUM_DIGITS - 1 - k;
            all_zero = all_zero && (value[4*i +: 4] == 4'h0);
            m[i]     = lz && all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: phase counter for the display scan.
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous return to 0 (phase change or scan disabled)
//   last_count  - terminal value of the current phase (phase length - 1)
//   tc          - high while the count equals last_count
module scan_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] last_count,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tc = (count == last_count);

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexes one seven-segment decoder across
// four digits with dead time between slots, per-digit and leading-zero blanking.
//   clk, reset   - clock, asynchronous active-high reset
//   enable       - scanning enable; low holds the display dark at digit 0
//   load         - strobe capturing value/blank_mask/lz_blank into pending
//   value        - four hex digits, value[3:0] is digit 0 (rightmost)
//   blank_mask   - bit i forces digit i dark
//   lz_blank     - suppress leading zeros
//   nib          - nibble to the decoder
//   an           - active-low anode select, bit i drives digit i
//   frame_done   - one-cycle pulse on the first cycle of digit 0's BLANK phase
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    input  logic        lz_blank,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned MAX_LEN = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        phase_end;
    logic        frame_end;
    logic        transfer;

    logic [15:0] act_value, act_value_nxt;
    logic [3:0]  act_mask, act_mask_nxt;
    logic        act_lz, act_lz_nxt;
    logic [15:0] pend_value;
    logic [3:0]  pend_mask;
    logic        pend_lz;
    logic        pend_valid;

    logic [3:0]  digit_blank;
    logic [3:0]  an_nxt;
    logic [3:0]  nib_nxt;

    scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!enable || phase_end),
        .last_count ((state == ST_DRIVE) ? DRIVE_LAST : BLANK_LAST),
        .tc         (phase_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BLANK;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe rather than lagging by a cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        frame_end = 1'b0;
        if (!enable) begin
            state_nxt = ST_BLANK;
            idx_nxt   = '0;
        end else if (phase_end) begin
            case (state)
                ST_BLANK: state_nxt = ST_DRIVE;
                ST_DRIVE: begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = idx + 2'd1;
                    frame_end = (idx == 2'd3);
                end
                default:  state_nxt = ST_BLANK;
            endcase
        end

        transfer      = pend_valid && (!enable || frame_end);
        act_value_nxt = transfer ? pend_value : act_value;
        act_mask_nxt  = transfer ? pend_mask  : act_mask;
        act_lz_nxt    = transfer ? pend_lz    : act_lz;

        // The active word only changes on entry to BLANK or while disabled,
        // so the current copy is the right one for any DRIVE decision.
        digit_blank = act_mask | lz_mask(act_value, act_lz);

        an_nxt = ANODE_OFF;
        if (state_nxt == ST_DRIVE && !digit_blank[idx_nxt])
            an_nxt = ~(4'b0001 << idx_nxt);

        nib_nxt = nib;
        if (state_nxt == ST_BLANK && (state == ST_DRIVE || !enable))
            nib_nxt = act_value_nxt[{idx_nxt, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= ANODE_OFF;
            nib        <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            nib        <= nib_nxt;
            frame_done <= frame_end;
        end
    end

    // A load on the transfer edge stays pending: transfer takes the old
    // pending contents and pend_valid is re-set by the new load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_value <= '0;
            pend_mask  <= '1;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_mask  <= blank_mask;
                pend_lz    <= lz_blank;
                pend_valid <= 1'b1;
            end else if (transfer) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_value <= '0;
            act_mask  <= '1;
            act_lz    <= 1'b0;
        end else begin
            act_value <= act_value_nxt;
            act_mask  <= act_mask_nxt;
            act_lz    <= act_lz_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed self-checking bench for
// display_scan_controller with REFRESH_DIV=4, DEAD_CYCLES=2
// (slot 6 cycles, frame 24). Inputs driven and outputs sampled on negedge.
module tb_display_scan_controller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        lz_blank;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        frame_done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    display_scan_controller #(
        .REFRESH_DIV (4),
        .DEAD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_blank   (lz_blank),
        .nib        (nib),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic lz);
        value      = v;
        blank_mask = m;
        lz_blank   = lz;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Advance to the next frame_done cycle, bounded.
    task automatic sync_frame();
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("sync_frame", {15'd0, found}, 16'd1);
    endtask

    // Checks one full frame starting at cycle 0 of digit 0's BLANK phase;
    // returns aligned to the next frame's cycle 0.
    task automatic expect_frame(input logic [15:0] val, input logic [3:0] blank,
                                input logic fd_first);
        for (int unsigned d = 0; d < 4; d++) begin
            for (int unsigned c = 0; c < 6; c++) begin
                logic [3:0] exp_an;
                logic [3:0] exp_nib;
                logic       exp_fd;
                exp_nib = val[4*d +: 4];
                exp_an  = (c < 2 || blank[d]) ? 4'hF : ~(4'b0001 << d);
                exp_fd  = (d == 0 && c == 0) ? fd_first : 1'b0;
                check($sformatf("d%0d c%0d an", d, c), {12'd0, an}, {12'd0, exp_an});
                check($sformatf("d%0d c%0d nib", d, c), {12'd0, nib}, {12'd0, exp_nib});
                check($sformatf("d%0d c%0d frame_done", d, c), {15'd0, frame_done},
                      {15'd0, exp_fd});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        value      = '0;
        blank_mask = '0;
        lz_blank   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst an", {12'd0, an}, 16'h000F);
        check("rst nib", {12'd0, nib}, 16'h0000);
        check("rst frame_done", {15'd0, frame_done}, 16'd0);

        // 1. Reset state scanning: dark display, frame_done every 24 cycles.
        reset  = 1'b0;
        enable = 1'b1;
        for (int unsigned i = 1; i <= 24; i++) begin
            @(negedge clk);
            check($sformatf("first fd cyc%0d", i), {15'd0, frame_done},
                  {15'd0, (i == 24)});
        end
        expect_frame(16'h0000, 4'b1111, 1'b1);
        expect_frame(16'h0000, 4'b1111, 1'b1);

        // 2. Basic scan.
        do_load(16'h1234, 4'b0000, 1'b0);
        sync_frame();
        expect_frame(16'h1234, 4'b0000, 1'b1);

        // 3. Leading-zero blanking.
        do_load(16'h0070, 4'b0000, 1'b1);
        sync_frame();
        expect_frame(16'h0070, 4'b1100, 1'b1);
        do_load(16'h0000, 4'b0000, 1'b1);
        sync_frame();
        expect_frame(16'h0000, 4'b1110, 1'b1);

        // 4. Double load mid-frame, last wins.
        repeat (5) @(negedge clk);
        value      = 16'h1111;
        blank_mask = 4'b0000;
        lz_blank   = 1'b0;
        load       = 1'b1;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        sync_frame();
        expect_frame(16'h2222, 4'b0000, 1'b1);
        // Load on the frame-boundary edge shows one frame later.
        repeat (23) @(negedge clk);
        do_load(16'h3333, 4'b0000, 1'b0);
        expect_frame(16'h2222, 4'b0000, 1'b1);
        expect_frame(16'h3333, 4'b0000, 1'b1);

        // 5. Disable mid-DRIVE of digit 2.
        repeat (15) @(negedge clk);
        check("pre-disable an", {12'd0, an}, 16'h000B);
        check("pre-disable nib", {12'd0, nib}, 16'h0003);
        enable = 1'b0;
        @(negedge clk);
        check("disabled an", {12'd0, an}, 16'h000F);
        do_load(16'h00A5, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        check("disabled an2", {12'd0, an}, 16'h000F);
        check("disabled nib", {12'd0, nib}, 16'h0005);
        check("disabled fd", {15'd0, frame_done}, 16'd0);
        enable = 1'b1;
        expect_frame(16'h00A5, 4'b0000, 1'b0);
        check("fd after enable", {15'd0, frame_done}, 16'd1);

        // 6. Asynchronous reset during DRIVE.
        repeat (3) @(negedge clk);
        check("pre-reset an", {12'd0, an}, 16'h000E);
        check("pre-reset nib", {12'd0, nib}, 16'h0005);
        #2;
        reset = 1'b1;
        #1;
        check("async an", {12'd0, an}, 16'h000F);
        check("async nib", {12'd0, nib}, 16'h0000);
        check("async fd", {15'd0, frame_done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        sync_frame();
        expect_frame(16'h0000, 4'b1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexes the shared seven-segment decoder across the four digits of the reaction-time display. The block holds a double-buffered 16-bit display word and steps through its nibbles one digit slot at a time. For each slot it presents the nibble to the decoder inputs and drives the matching active-low anode. A dead-time gap between slots prevents ghosting, and the block also provides per-digit and leading-zero blanking.

## Interface
- `REFRESH_DIV`, 50000, DRIVE-phase length per digit in clock cycles; must be ≥1.
- `DEAD_CYCLES`, 500, BLANK-phase length per digit in clock cycles; must be ≥1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: scanning enable.
- `load` in 1: single-cycle strobe; captures `value`, `blank_mask` and `lz_blank`.
- `value` in 16: four hex digits; `value[3:0]` is digit 0 (rightmost).
- `blank_mask` in 4: bit i=1 forces digit i dark.
- `lz_blank` in 1: suppress leading zeros.
- `nib` out 4: nibble to the decoder, `nib[3:0]` wired to X3..X0.
- `an` out 4: active-low anode select, bit i drives digit i.
- `frame_done` out 1: one-cycle pulse at the end of digit 3's DRIVE phase.

## Operation
- **Pending register.** `load` high at an edge copies value, mask and lz into it and sets `pend_valid`. A later load before transfer overwrites it; last load wins.
- **Active register.** Drives the display. It takes the pending contents only at a frame boundary (idx 3→0), then clears `pend_valid`; no mid-frame tearing. A load and a frame boundary on the same edge: the transfer uses the old pending contents, and the new load stays pending (`pend_valid` stays 1).
- **State machine.**
  - ST_BLANK: `an`=1111; `nib`=active nibble[idx]. After DEAD_CYCLES cycles → ST_DRIVE.
  - ST_DRIVE: `an`=~(1<<idx) unless digit idx is blanked, in which case `an`=1111. After REFRESH_DIV cycles → ST_BLANK with idx+1 mod 4.
  - Leaving DRIVE with idx=3: idx wraps to 0, `frame_done` pulses, pending→active transfer occurs.
- **Blanking.** Digit i is blanked if active mask[i]=1, or if lz=1 and i≠0 and nibbles 3..i are all zero. Digit 0 is never zero-suppressed.
- **Disable.** `enable`=0 forces ST_BLANK, idx=0, counter=0, `an`=1111. While disabled, pending transfers to active on every cycle it is valid. On `enable` rise, scanning starts with the BLANK phase of digit 0.
- **Counter.** Width is the ceiling of log2(max(REFRESH_DIV, DEAD_CYCLES)). It counts 0..N-1 in each phase, resets to 0 on a phase change, and never wraps otherwise.

## Timing
- **Reset values:** `an`=1111, `nib`=0000, `frame_done`=0, state ST_BLANK, idx=0, counter=0, active and pending value=0, mask=1111, lz=0, `pend_valid`=0.
- **Reset mid-scan:** outputs go to reset values immediately (asynchronous), not at the next edge.
- All outputs are registered.
- `nib` changes only on entry to ST_BLANK, so it is stable for DEAD_CYCLES cycles before its anode turns on.
- Slot = DEAD_CYCLES + REFRESH_DIV cycles; frame = 4 × slot.
- Load-to-display latency: up to one frame plus one slot.
- `frame_done` is high for exactly the first cycle of digit 0's BLANK phase.

## Structure
- **Package `display_pkg`:**
  - NUM_DIGITS=4
  - ANODE_OFF=4'b1111
  - state enum {ST_BLANK, ST_DRIVE}
  - function `lz_mask(value, lz)` returning the 4-bit blank vector.
- **Sub-module `scan_timer`:** phase counter with a terminal-count output and a clear input, parameterised by the current phase length.
- The decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use REFRESH_DIV=4 and DEAD_CYCLES=2 (slot 6 cycles, frame 24).
1. **Reset.** Release reset with enable=1, no load → `an` stays 1111 for 48 cycles (mask=1111); `frame_done` pulses every 24 cycles; `nib`=0.
2. **Basic scan.** load value=0x1234, mask=0000 → from the next frame, `an` sequence 1110/1101/1011/0111, each low 4 cycles separated by 2 cycles of 1111; `nib` shows 4, 3, 2, 1, each stable 2 cycles before its anode.
3. **Leading-zero blanking.** load value=0x0070, lz=1, mask=0000 → digits 3 and 2 dark; digit 1 shows 7; digit 0 shows 0 and is lit. Repeat with value=0x0000 → only digit 0 lit.
4. **Double load / same-edge load.** Two loads (0x1111 then 0x2222) mid-frame → next frame shows 2222 only. A load coinciding with the frame-boundary edge appears one frame later.
5. **Disable.** Drop enable mid-DRIVE of digit 2 → `an`=1111 on the next edge. Re-enable → 2 cycles BLANK, then digit 0 DRIVE.
6. **Async reset.** Assert reset between clock edges during DRIVE → `an`=1111 and `nib`=0 before the next clock edge; active value returns to 0 with mask 1111.
